// File: rtl/traffic_phase_sequencer.sv
// Tick-timed traffic phase FSM producing the 2-bit lamp code for the decoder.
// Optional flashing-amber override enabled by defining TRAFFIC_FLASH_MODE_EN.
module traffic_phase_sequencer #(
    parameter int TICK_DIV        = 10,
    parameter int RED_TICKS       = 8,
    parameter int RED_YEL_TICKS   = 2,
    parameter int GREEN_MIN_TICKS = 6,
    parameter int GREEN_MAX_TICKS = 15,
    parameter int YEL_TICKS       = 3,
    parameter int DEB_CYCLES      = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic ped_req_raw,
    input  logic veh_sense,
`ifdef TRAFFIC_FLASH_MODE_EN
    input  logic flash_req,
`endif
    output logic out_a,
    output logic out_b,
    output logic phase_start,
    output logic ped_ack
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_DUR = max2(max2(RED_TICKS, RED_YEL_TICKS),
                                  max2(GREEN_MAX_TICKS, YEL_TICKS));
    localparam int CNT_W   = (MAX_DUR > 0) ? $clog2(MAX_DUR + 1) : 1;
    localparam int DEB_W   = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    if (TICK_DIV < 1 || DEB_CYCLES < 1 || RED_TICKS < 1 ||
        RED_YEL_TICKS < 1 || GREEN_MIN_TICKS < 1 || YEL_TICKS < 1 ||
        GREEN_MAX_TICKS < GREEN_MIN_TICKS) begin : g_bad_cfg
        $error("traffic_phase_sequencer: illegal duration parameters");
    end

    typedef enum logic [1:0] {
        RED     = 2'b00,
        RED_YEL = 2'b01,
        GREEN   = 2'b10,
        YEL     = 2'b11
    } state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   phase_cnt, cnt_nx;
    logic [DEB_W-1:0]   deb_cnt;
    logic               tick, go;
    logic               ped_s1, ped_s2, ped_db, ped_db_q;
    logic               ped_rise, ped_pending;

    assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign ped_rise = ped_db & ~ped_db_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES clean mismatches
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ped_s1   <= 1'b0;
            ped_s2   <= 1'b0;
            ped_db   <= 1'b0;
            ped_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            ped_s1   <= ped_req_raw;
            ped_s2   <= ped_s1;
            ped_db_q <= ped_db;
            if (ped_s2 != ped_db) begin
                if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    ped_db  <= ped_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ped_pending <= 1'b0;
        end else if (ped_ack) begin
            ped_pending <= 1'b0;
        end else if (ped_rise) begin
            ped_pending <= 1'b1;
        end
    end

`ifdef TRAFFIC_FLASH_MODE_EN
    logic flash_s1, flash_sync, flash, flash_on;
    logic flash_nx, flash_on_nx;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            flash_s1   <= 1'b0;
            flash_sync <= 1'b0;
            flash      <= 1'b0;
            flash_on   <= 1'b0;
        end else begin
            flash_s1   <= flash_req;
            flash_sync <= flash_s1;
            flash      <= flash_nx;
            flash_on   <= flash_on_nx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= RED;
            phase_cnt   <= '0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_nx;
            phase_cnt   <= cnt_nx;
            phase_start <= go;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = phase_cnt;
        go       = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
        flash_nx    = flash;
        flash_on_nx = flash_on;
`endif
        if (tick) begin
            cnt_nx = phase_cnt + 1'b1;
            unique case (state)
                RED: if (phase_cnt == CNT_W'(RED_TICKS - 1))
                    state_nx = RED_YEL;
                RED_YEL: if (phase_cnt == CNT_W'(RED_YEL_TICKS - 1))
                    state_nx = GREEN;
                GREEN: if (phase_cnt == CNT_W'(GREEN_MAX_TICKS - 1) ||
                           (phase_cnt >= CNT_W'(GREEN_MIN_TICKS - 1) &&
                            (ped_pending || !veh_sense)))
                    state_nx = YEL;
                YEL: if (phase_cnt == CNT_W'(YEL_TICKS - 1))
                    state_nx = RED;
            endcase
            go = (state_nx != state);
            if (go) cnt_nx = '0;
`ifdef TRAFFIC_FLASH_MODE_EN
            // Flash parks the FSM in RED so leaving it is a plain RED entry
            if (flash) begin
                state_nx = RED;
                cnt_nx   = '0;
                go       = 1'b1;
                if (flash_sync) flash_on_nx = ~flash_on;
                else            flash_nx    = 1'b0;
            end else if (flash_sync) begin
                state_nx    = RED;
                cnt_nx      = '0;
                go          = 1'b1;
                flash_nx    = 1'b1;
                flash_on_nx = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        {out_a, out_b} = state;
        ped_ack = phase_start && (state == RED) && (ped_pending || ped_rise);
`ifdef TRAFFIC_FLASH_MODE_EN
        if (flash) begin
            {out_a, out_b} = {1'b0, flash_on};
            ped_ack        = 1'b0;
        end
`endif
    end

endmodule
